// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment scan driver.
// Segment encodings are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with snapshot latch and scan prescaler.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        CP,
    input  logic        Rd,
    input  logic        LD,
    input  logic [15:0] bcd,
    output logic [6:0]  seg,
    output logic [3:0]  dig_sel
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [NUM_DIGITS-1:0][3:0] latch_r;
    logic [PW-1:0]              presc_r;
    logic [1:0]                 idx_r;
    logic [3:0]                 digit_s;
    logic [6:0]                 dec_s;
    logic [6:0]                 seg_s;
    logic                       blank_s;

    // Snapshot latch: freezes the counter value the display shows
    always_ff @(posedge CP or posedge Rd) begin
        if (Rd) begin
            latch_r <= 16'h0000;
        end else if (LD) begin
            latch_r <= bcd;
        end else begin
            latch_r <= latch_r;
        end
    end

    // Prescaler and scan index; idx moves on the prescaler wrap edge
    always_ff @(posedge CP or posedge Rd) begin
        if (Rd) begin
            presc_r <= '0;
            idx_r   <= 2'd0;
        end else if (presc_r == PRESC_MAX) begin
            presc_r <= '0;
            idx_r   <= idx_r + 2'd1;
        end else begin
            presc_r <= presc_r + PW'(1);
            idx_r   <= idx_r;
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (digit_s),
        .seg (dec_s)
    );

    // Digit mux and optional blanking of leading zeros (digit 0 never blanks)
    always_comb begin
        digit_s = latch_r[idx_r];
        blank_s = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
        case (idx_r)
            2'd3:    blank_s = (latch_r[3] == 4'd0);
            2'd2:    blank_s = (latch_r[3] == 4'd0) && (latch_r[2] == 4'd0);
            2'd1:    blank_s = (latch_r[3] == 4'd0) && (latch_r[2] == 4'd0) &&
                               (latch_r[1] == 4'd0);
            default: blank_s = 1'b0;
        endcase
`else
        blank_s = 1'b0;
`endif
        if (blank_s) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = dec_s;
        end
    end

    // Output registers: segments and select always update together
    always_ff @(posedge CP or posedge Rd) begin
        if (Rd) begin
            seg     <= SEG_BLANK;
            dig_sel <= 4'b1111;
        end else begin
            seg     <= seg_s;
            dig_sel <= ~(4'b0001 << idx_r);
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (SCAN_DIV=4) against an edge-count based reference model.
module tb_seg7_scan;

    localparam int SCAN_DIV = 4;
    localparam logic [6:0] TAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef SEG7_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        CP;
    logic        Rd;
    logic        LD;
    logic [15:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;

    int          errors;
    int          checks;
    int          k;
    logic [3:0]  m_latch [4];

    seg7_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .CP      (CP),
        .Rd      (Rd),
        .LD      (LD),
        .bcd     (bcd),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    function automatic logic [6:0] exp_seg_f(input int i);
        bit all_zero;
        all_zero = 1'b1;
        for (int j = i; j < 4; j++) begin
            if (m_latch[j] != 4'd0) all_zero = 1'b0;
        end
        if (LZB && i > 0 && all_zero) return 7'h00;
        if (m_latch[i] > 4'd9) return 7'h40;
        return TAB[m_latch[i]];
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0;
        for (int j = 0; j < 4; j++) m_latch[j] = 4'd0;
    endtask

    // One CP edge: output shows the pre-edge latch at the index for edge number k
    task automatic tick(input logic ld_v, input logic [15:0] bcd_v);
        int          id;
        logic [6:0]  es;
        logic [3:0]  ed;
        LD  = ld_v;
        bcd = bcd_v;
        id  = (k / SCAN_DIV) % 4;
        es  = exp_seg_f(id);
        ed  = ~(4'b0001 << id);
        @(posedge CP);
        if (ld_v) begin
            for (int j = 0; j < 4; j++) m_latch[j] = bcd_v[j*4 +: 4];
        end
        k++;
        #1;
        check("seg", seg, es);
        check("dig_sel", {3'b000, dig_sel}, {3'b000, ed});
    endtask

    initial begin
        logic [3:0] dig_prev;
        errors = 0;
        checks = 0;
        Rd  = 1'b1;
        LD  = 1'b0;
        bcd = 16'h0000;
        model_reset();
        #1;
        check("reset_seg", seg, 7'h00);
        check("reset_dig", {3'b000, dig_sel}, 7'h0F);
        @(posedge CP);
        @(posedge CP);
        #1;
        check("reset_hold_dig", {3'b000, dig_sel}, 7'h0F);
        Rd = 1'b0;

        // First edge after release, then run into digit 2
        tick(1'b0, 16'h0000);
        check("first_seg", seg, 7'h3F);
        check("first_dig", {3'b000, dig_sel}, 7'h0E);
        for (int i = 0; i < 8; i++) tick(1'b0, 16'(i));
        check("mid_dig", {3'b000, dig_sel}, 7'h0B);

        // Mid-frame reset takes effect without a clock edge
        Rd = 1'b1;
        #1;
        check("async_rst_seg", seg, 7'h00);
        check("async_rst_dig", {3'b000, dig_sel}, 7'h0F);
        @(posedge CP);
        #1;
        check("rst_held_dig", {3'b000, dig_sel}, 7'h0F);
        Rd = 1'b0;
        model_reset();
        tick(1'b0, 16'h0000);
        check("post_rst_seg", seg, 7'h3F);
        check("post_rst_dig", {3'b000, dig_sel}, 7'h0E);

        // Scan order with 1234
        tick(1'b1, 16'h1234);
        for (int i = 0; i < 16; i++) tick(1'b0, 16'h0000);

        // Snapshot hold while bcd keeps changing
        tick(1'b1, 16'h5678);
        for (int i = 0; i < 32; i++) tick(1'b0, 16'($urandom));

        // Invalid digit and blanking patterns
        tick(1'b1, 16'h00A9);
        for (int i = 0; i < 16; i++) tick(1'b0, 16'($urandom));
        tick(1'b1, 16'h0000);
        for (int i = 0; i < 16; i++) tick(1'b0, 16'($urandom));
        tick(1'b1, 16'h0405);
        for (int i = 0; i < 16; i++) tick(1'b0, 16'($urandom));

        // LD on the prescaler wrap edge
        for (int i = 0; i < 8 && (k % SCAN_DIV) != (SCAN_DIV - 1); i++) tick(1'b0, 16'h0000);
        dig_prev = dig_sel;
        tick(1'b1, 16'h9999);
        tick(1'b0, 16'h0000);
        check("wrap_ld_seg", seg, 7'h6F);
        check("wrap_ld_dig", {3'b000, dig_sel}, {3'b000, dig_prev[2:0], dig_prev[3]});

        // Randomized snapshots
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(0, 3) == 0), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Four-digit multiplexed seven-segment display driver that consumes the BCD outputs of a cascade of four decade counters (units through thousands) and drives one shared segment bus plus four digit-select lines. It sits directly downstream of the counter chain. It holds a snapshot of the count so the display is stable while the counters keep running. It scans the digits at a rate set by an internal prescaler.

## Interface
- SCAN_DIV, default 50000, is the number of CP cycles each digit stays selected; the legal minimum is 2.
- CP, input, 1 bit, is the system clock; all state updates on the rising edge.
- Rd, input, 1 bit, is the reset: one clock, asynchronous, active-high.
- LD, input, 1 bit, is the snapshot strobe. When high at a CP edge, `bcd` is captured into the display latch.
- bcd, input, 16 bits, carries the counter outputs: [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- seg, output, 7 bits, is the segment bus {g,f,e,d,c,b,a}, active-high.
- dig_sel, output, 4 bits, is the digit select: active-low, one-hot, bit i selects digit i.

## Operation
- Display latch: 4×4 bits.
  - Captured from `bcd` on every CP edge with LD=1.
  - Holds its value otherwise.
- Prescaler:
  - Counts 0 to SCAN_DIV−1, then wraps to 0.
  - Width is $clog2(SCAN_DIV).
- Scan index `idx` (2 bits):
  - Advances 0→1→2→3→0 on the edge where the prescaler wraps from SCAN_DIV−1.
  - Holds otherwise.
- Output registers, on every edge:
  - `seg <= decode(latch[idx])`.
  - `dig_sel <= ~(4'b0001 << idx)`.
- Decode, valid digits:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
- Decode, invalid digits: any value 10–15 decodes to a dash, 0x40 (segment g only).
- Leading-zero blanking: see Configuration.
- Simultaneous LD and index advance at the same edge:
  - Both take effect.
  - The output on the next edge reflects the new latch and the new idx.
- LD held high continuously makes the display track `bcd`, with one cycle of latch delay.

## Timing
- Reset values while Rd=1, applied asynchronously and immediately:
  - latch = 0, prescaler = 0, idx = 0.
  - seg = 0x00 (blank).
  - dig_sel = 4'b1111 (all off).
- Reset mid-scan clears all state at once. No partial digit is completed.
- First CP edge after Rd falls: seg = decode(latch[0]) = 0x3F and dig_sel = 4'b1110.
- Steady state: each dig_sel value is held for exactly SCAN_DIV consecutive cycles, so a full frame takes 4×SCAN_DIV cycles.
- Latency:
  - bcd to latch: 1 edge.
  - latch or idx change to seg/dig_sel: 1 further edge.
  - Worst case, LD to a visible change on the selected digit: 2 edges.
- `seg` and `dig_sel` always change on the same edge. A selected digit never shows another digit's segments.

## Configuration
- Macro: SEG7_SCAN_LZB_EN.
- Defined: leading-zero blanking.
  - Digit i (i = 3, 2, 1) outputs seg = 0x00 when latch[i] and all higher latched digits are 0.
  - Digit 0 is never blanked.
  - dig_sel still scans normally.
- Not defined: every digit is decoded, so leading zeros display as 0x3F.
- Invalid values (10–15) count as non-zero for the blanking decision.

## Structure
- Package seg7_pkg holds:
  - the ten segment constants SEG_0…SEG_9;
  - SEG_BLANK = 7'h00 and SEG_DASH = 7'h40;
  - the digit count constant NUM_DIGITS = 4.
- Sub-module bcd_to_seg7: a purely combinational 4-bit to 7-bit decoder using the package constants, instantiated once on the muxed digit.
- Top level contains the latch, prescaler, idx, blanking logic (under the macro) and the output registers.

## Test plan
All scenarios use SCAN_DIV=4.
- **Reset:** assert Rd mid-frame with dig_sel=4'b1011 → seg=0x00 and dig_sel=4'b1111 immediately; first edge after release gives dig_sel=4'b1110, seg=0x3F.
- **Scan order:** LD pulse with bcd=16'h1234, then run 16 cycles → dig_sel steps 1110, 1101, 1011, 0111, each for 4 cycles; seg is 0x66, 0x4F, 0x5B, 0x06 respectively.
- **Snapshot hold:** LD pulse with bcd=16'h5678, then bcd changes every cycle with LD=0 → seg keeps showing 8, 7, 6, 5 (0x7F, 0x07, 0x7D, 0x6D) across two full frames.
- **Invalid digit:** latch 16'h00A9 → digit 1 shows 0x40 and digit 0 shows 0x6F. With SEG7_SCAN_LZB_EN, digits 3 and 2 show 0x00 and digit 1 still shows 0x40.
- **Blanking:** latch 16'h0000 → with SEG7_SCAN_LZB_EN, digits 3–1 show 0x00 and digit 0 shows 0x3F; without the macro, all four show 0x3F. Latch 16'h0405 → with the macro, only digit 3 is blank.
- **Simultaneous LD and wrap:** assert LD with bcd=16'h9999 on the edge where the prescaler wraps 3→0 → the next edge shows dig_sel advanced by one position and seg=0x6F.
